// File: rtl/k12a_lcd_ctl_pkg.sv
// Shared types and constants for the k12a HD44780 LCD sequencer.
package k12a_lcd_ctl_pkg;

    localparam int unsigned LCD_DATA_W = 8;

    typedef enum logic [2:0] {
        LCD_IDLE,
        LCD_SETUP,
        LCD_ENABLE,
        LCD_HOLD,
        LCD_WAIT,
        LCD_POWERUP,
        LCD_INIT
    } lcd_state_t;

    typedef struct packed {
        logic                  rs;
        logic [LCD_DATA_W-1:0] data;
    } lcd_req_t;

    localparam logic [LCD_DATA_W-1:0] LCD_CMD_CLEAR  = 8'h01;
    localparam logic [LCD_DATA_W-1:0] LCD_CMD_HOME   = 8'h02;
    localparam logic [LCD_DATA_W-1:0] LCD_INIT_FUNC  = 8'h38;
    localparam logic [LCD_DATA_W-1:0] LCD_INIT_DISP  = 8'h0C;
    localparam logic [LCD_DATA_W-1:0] LCD_INIT_ENTRY = 8'h06;
    localparam logic [LCD_DATA_W-1:0] LCD_INIT_CLEAR = 8'h01;

    // Power-on command sequence, selected by a 2-bit index.
    function automatic logic [LCD_DATA_W-1:0] lcd_init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_INIT_FUNC;
            2'd1:    return LCD_INIT_DISP;
            2'd2:    return LCD_INIT_ENTRY;
            default: return LCD_INIT_CLEAR;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long execution wait.
    function automatic logic is_long_cmd(input lcd_req_t req);
        return !req.rs && ((req.data == LCD_CMD_CLEAR) ||
                           (req.data[LCD_DATA_W-1:1] == LCD_CMD_HOME[LCD_DATA_W-1:1]));
    endfunction

endpackage

// File: rtl/k12a_lcd_ctl_if.sv
// Request handshake and LCD pin bundle between the k12a I/O block and the LCD sequencer.
interface k12a_lcd_ctl_if;

    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

endinterface

// File: rtl/k12a_lcd_timer.sv
// Loadable down-counter that stops at zero; zero_o is registered alongside the count.
module k12a_lcd_timer #(
    parameter int unsigned      CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            cnt_q  <= RST_VAL;
            zero_q <= (RST_VAL == '0);
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/k12a_lcd_ctl.sv
// HD44780 write sequencer: setup / enable / hold / execution-wait timing per accepted byte.
// Optional power-on init sequence under K12A_LCD_INIT_EN.
module k12a_lcd_ctl
    import k12a_lcd_ctl_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES      = 4,
    parameter int unsigned EN_CYCLES         = 12,
    parameter int unsigned HOLD_CYCLES       = 4,
    parameter int unsigned SHORT_WAIT_CYCLES = 50,
    parameter int unsigned LONG_WAIT_CYCLES  = 2000,
    parameter int unsigned CNT_W             = 16
) (
    input  logic            sys_clock,
    input  logic            reset,
    k12a_lcd_ctl_if.slave   bus
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYCLES - 1);

`ifdef K12A_LCD_INIT_EN
    localparam lcd_state_t       RST_STATE = LCD_POWERUP;
    localparam logic [CNT_W-1:0] TMR_RST   = CNT_W'(LONG_WAIT_CYCLES * 8 - 1);
`else
    localparam lcd_state_t       RST_STATE = LCD_IDLE;
    localparam logic [CNT_W-1:0] TMR_RST   = '0;
`endif
    localparam logic RST_READY = (RST_STATE == LCD_IDLE);

    lcd_state_t       state_q, state_d;
    lcd_req_t         req_q, req_d;
    logic             en_q, ready_q, busy_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;
`ifdef K12A_LCD_INIT_EN
    logic [1:0]       idx_q, idx_d;
    logic             init_q, init_d;
`endif

    k12a_lcd_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .zero_o       (tmr_zero)
    );

    // Next state, latched request and timer reloads on each state entry.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
`ifdef K12A_LCD_INIT_EN
        idx_d     = idx_q;
        init_d    = init_q;
`endif
        case (state_q)
            LCD_IDLE: begin
                if (bus.req_valid) begin
                    state_d   = LCD_SETUP;
                    req_d     = '{rs: bus.req_rs, data: bus.req_data};
                    tmr_load  = 1'b1;
                    tmr_value = SETUP_LD;
                end
            end
            LCD_SETUP: begin
                if (tmr_zero) begin
                    state_d   = LCD_ENABLE;
                    tmr_load  = 1'b1;
                    tmr_value = EN_LD;
                end
            end
            LCD_ENABLE: begin
                if (tmr_zero) begin
                    state_d   = LCD_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_LD;
                end
            end
            LCD_HOLD: begin
                if (tmr_zero) begin
                    state_d   = LCD_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = is_long_cmd(req_q) ? LONG_LD : SHORT_LD;
                end
            end
            LCD_WAIT: begin
                if (tmr_zero) begin
                    state_d = LCD_IDLE;
`ifdef K12A_LCD_INIT_EN
                    if (init_q) begin
                        if (idx_q == 2'd3) begin
                            init_d = 1'b0;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = LCD_INIT;
                        end
                    end
`endif
                end
            end
`ifdef K12A_LCD_INIT_EN
            LCD_POWERUP: begin
                if (tmr_zero) begin
                    state_d = LCD_INIT;
                end
            end
            LCD_INIT: begin
                state_d   = LCD_SETUP;
                req_d     = '{rs: 1'b0, data: lcd_init_byte(idx_q)};
                tmr_load  = 1'b1;
                tmr_value = SETUP_LD;
            end
`endif
            default: state_d = LCD_IDLE;
        endcase
    end

    // State and registered pin/status outputs derived from the next state.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q <= RST_STATE;
            req_q   <= '0;
            en_q    <= 1'b0;
            ready_q <= RST_READY;
            busy_q  <= !RST_READY;
`ifdef K12A_LCD_INIT_EN
            idx_q   <= 2'd0;
            init_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            en_q    <= (state_d == LCD_ENABLE);
            ready_q <= (state_d == LCD_IDLE);
            busy_q  <= (state_d != LCD_IDLE);
`ifdef K12A_LCD_INIT_EN
            idx_q   <= idx_d;
            init_q  <= init_d;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.lcd_rs    = req_q.rs;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_en    = en_q;
    assign bus.lcd_data  = req_q.data;

endmodule

// File: tb/tb_k12a_lcd_ctl.sv
// Randomized self-checking bench for k12a_lcd_ctl against a cycle-offset timing model.
module tb_k12a_lcd_ctl;

    localparam int unsigned S  = 4;
    localparam int unsigned E  = 12;
    localparam int unsigned H  = 4;
    localparam int unsigned SW = 50;
    localparam int unsigned LW = 2000;

    logic sys_clock = 1'b0;
    logic reset     = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [12:0] obs, exp_v;

    k12a_lcd_ctl_if lcd_if ();

    k12a_lcd_ctl #(
        .SETUP_CYCLES      (S),
        .EN_CYCLES         (E),
        .HOLD_CYCLES       (H),
        .SHORT_WAIT_CYCLES (SW),
        .LONG_WAIT_CYCLES  (LW),
        .CNT_W             (16)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (lcd_if)
    );

    always #5 sys_clock = ~sys_clock;

    // Expected wait after a write: clear/home commands are long, everything else short.
    function automatic int unsigned model_wait(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LW;
        return SW;
    endfunction

    function automatic int unsigned model_total(input logic rs, input logic [7:0] d);
        return S + E + H + model_wait(rs, d);
    endfunction

    // {ready, busy, en, rw, rs, data} k cycles after the accepting edge.
    function automatic logic [12:0] model_out(input int unsigned k, input logic rs, input logic [7:0] d);
        logic rdy, en;
        rdy = (k >= model_total(rs, d));
        en  = (k >= S) && (k < S + E);
        return {rdy, !rdy, en, 1'b0, rs, d};
    endfunction

    function automatic logic [12:0] sample();
        return {lcd_if.req_ready, lcd_if.busy, lcd_if.lcd_en, lcd_if.lcd_rw, lcd_if.lcd_rs, lcd_if.lcd_data};
    endfunction

    task automatic step();
        @(posedge sys_clock);
        @(negedge sys_clock);
    endtask

    // Present one request for a single edge, then drop valid.
    task automatic send(input logic rs, input logic [7:0] d);
        lcd_if.req_valid = 1'b1;
        lcd_if.req_rs    = rs;
        lcd_if.req_data  = d;
        step();
        lcd_if.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lcd_if.req_valid = 1'b0;
        lcd_if.req_rs    = 1'b0;
        lcd_if.req_data  = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            obs = sample();
            vectors++;
            if (obs !== 13'b1_0_0_0_0_00000000) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, 13'b1_0_0_0_0_00000000);
            end
        end
    endtask

    task automatic test_single_write();
        send(1'b1, 8'h41);
        for (int unsigned k = 0; k <= model_total(1'b1, 8'h41); k++) begin
            obs = sample();
            exp_v = model_out(k, 1'b1, 8'h41);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL single_write k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k < model_total(1'b1, 8'h41)) step();
        end
    endtask

    task automatic test_commands();
        logic       rs;
        logic [7:0] d;
        for (int n = 0; n < 8; n++) begin
            if (n == 0)      begin rs = 1'b0; d = 8'h01; end
            else if (n == 1) begin rs = 1'b0; d = 8'h38; end
            else begin
                rs = 1'($urandom);
                d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) step();
            vectors++;
            if (lcd_if.req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL cmd_ready_before n=%0d got=%b exp=1", n, lcd_if.req_ready);
            end
            send(rs, d);
            for (int unsigned k = 0; k <= model_total(rs, d); k++) begin
                obs = sample();
                exp_v = model_out(k, rs, d);
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL cmd n=%0d rs=%b d=%h k=%0d got=%h exp=%h", n, rs, d, k, obs, exp_v);
                end
                if (k < model_total(rs, d)) step();
            end
        end
    endtask

    task automatic test_back_to_back();
        lcd_if.req_valid = 1'b1;
        lcd_if.req_rs    = 1'b1;
        lcd_if.req_data  = 8'h41;
        step();
        lcd_if.req_data  = 8'h42;
        // 0x42 stays valid throughout the first transfer and must be ignored until IDLE.
        for (int unsigned k = 0; k <= model_total(1'b1, 8'h41); k++) begin
            obs = sample();
            exp_v = model_out(k, 1'b1, 8'h41);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_first k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k < model_total(1'b1, 8'h41)) step();
        end
        step();
        lcd_if.req_valid = 1'b0;
        for (int unsigned k = 0; k <= model_total(1'b1, 8'h42); k++) begin
            obs = sample();
            exp_v = model_out(k, 1'b1, 8'h42);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL b2b_second k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k < model_total(1'b1, 8'h42)) step();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom_range(8'h10, 8'hFF));
        send(1'b0, d);
        for (int unsigned k = 0; k <= S + 2; k++) begin
            obs = sample();
            exp_v = model_out(k, 1'b0, d);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL rst_mid_pre k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k < S + 2) step();
        end
        reset = 1'b1;
        step();
        obs = sample();
        vectors++;
        if (obs !== 13'b1_0_0_0_0_00000000) begin
            miscompares++;
            $display("FAIL rst_mid_abort got=%h exp=%h", obs, 13'b1_0_0_0_0_00000000);
        end
        reset = 1'b0;
        step();
        send(1'b0, 8'h38);
        for (int unsigned k = 0; k <= model_total(1'b0, 8'h38); k++) begin
            obs = sample();
            exp_v = model_out(k, 1'b0, 8'h38);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL rst_mid_recover k=%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k < model_total(1'b0, 8'h38)) step();
        end
    endtask

`ifdef K12A_LCD_INIT_EN
    task automatic test_init();
        logic [7:0]  init_bytes [4];
        int unsigned rise_k [$];
        logic [8:0]  rise_v [$];
        int unsigned done_k;
        logic        prev_en;
        init_bytes[0] = 8'h38;
        init_bytes[1] = 8'h0C;
        init_bytes[2] = 8'h06;
        init_bytes[3] = 8'h01;
        // Power-up delay, then per byte: one init cycle + setup/enable/hold + its wait.
        done_k = LW * 8 + 4 * (1 + S + E + H) + 3 * SW + LW;
        reset = 1'b1;
        lcd_if.req_valid = 1'b0;
        lcd_if.req_rs    = 1'b0;
        lcd_if.req_data  = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        prev_en = 1'b0;
        for (int unsigned k = 0; k <= done_k; k++) begin
            if (lcd_if.lcd_en && !prev_en) begin
                rise_k.push_back(k);
                rise_v.push_back({lcd_if.lcd_rs, lcd_if.lcd_data});
            end
            prev_en = lcd_if.lcd_en;
            vectors++;
            if ({lcd_if.req_ready, lcd_if.busy} !== ((k == done_k) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL init_busy k=%0d got=%b%b", k, lcd_if.req_ready, lcd_if.busy);
            end
            if (k < done_k) step();
        end
        vectors++;
        if (rise_k.size() != 4) begin
            miscompares++;
            $display("FAIL init_pulse_count got=%0d exp=4", rise_k.size());
        end
        for (int i = 0; i < 4 && i < rise_k.size(); i++) begin
            vectors++;
            if (rise_v[i] !== {1'b0, init_bytes[i]} ||
                rise_k[i] != LW * 8 + 1 + S + i * (1 + S + E + H + SW)) begin
                miscompares++;
                $display("FAIL init_byte i=%0d got=%h@%0d exp=%h@%0d", i, rise_v[i], rise_k[i],
                         {1'b0, init_bytes[i]}, LW * 8 + 1 + S + i * (1 + S + E + H + SW));
            end
        end
    endtask
`endif

    initial begin
        lcd_if.req_valid = 1'b0;
        lcd_if.req_rs    = 1'b0;
        lcd_if.req_data  = 8'h00;
        @(negedge sys_clock);
`ifdef K12A_LCD_INIT_EN
        test_init();
`else
        test_reset();
        test_single_write();
        test_commands();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
